// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StData,
        StLast,
        StCsum,
        StDone,
        StErr
    } state_t;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid marks the fourth byte.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q;
    logic [23:0] acc_q;

    // The first three bytes shift down so byte 0 ends up in [7:0].
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            idx_q <= 2'd0;
            acc_q <= 24'd0;
        end else if (byte_valid) begin
            idx_q <= idx_q + 2'd1;
            acc_q <= {byte_data, acc_q[23:8]};
        end
    end

    always_comb begin
        word_valid = byte_valid && (idx_q == 2'(BYTES_PER_WORD - 1));
        word       = {byte_data, acc_q};
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header + LE byte stream into instruction memory, core held until done.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t      state_q, state_d;
    logic [15:0] n_q;
    logic [15:0] word_cnt_q;
    logic        we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0] wdata_q;
    logic        clear;
    logic        xfer;
    logic        byte_valid;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] hdr_n;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign xfer       = s_valid && s_ready;
    assign byte_valid = xfer && (state_q == StData);
    assign hdr_n      = {s_data, n_q[7:0]};
    assign last_word  = (word_cnt_q == n_q - 16'd1);

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .byte_valid (byte_valid),
        .byte_data  (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StHdr0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            StHdr0: begin
                s_ready = 1'b1;
                if (xfer) state_d = StHdr1;
            end
            StHdr1: begin
                s_ready = 1'b1;
                if (xfer) begin
                    if (hdr_n == 16'd0) begin
                        state_d = StDone;
                    end else if (32'(hdr_n) > MAX_WORDS) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                s_ready = 1'b1;
                if (word_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d = StLast;
`endif
                end
            end
            StLast: state_d = StDone;
            StCsum: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                s_ready = 1'b1;
                if (xfer) state_d = (s_data == csum_q) ? StDone : StErr;
`else
                state_d = StHdr0;
`endif
            end
            StDone, StErr: begin
                if (reload) begin
                    state_d = StHdr0;
                    clear   = 1'b1;
                end
            end
            default: state_d = StHdr0;
        endcase
    end

    // Write port is registered; address and data hold between pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            n_q        <= 16'd0;
            word_cnt_q <= 16'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
        end else begin
            we_q <= 1'b0;
            if (clear) begin
                n_q        <= 16'd0;
                word_cnt_q <= 16'd0;
            end
            if (xfer && state_q == StHdr0) n_q[7:0]  <= s_data;
            if (xfer && state_q == StHdr1) n_q[15:8] <= s_data;
            if (word_valid) begin
                we_q       <= 1'b1;
                addr_q     <= word_cnt_q[ADDR_W-1:0];
                wdata_q    <= word;
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            csum_q <= 8'd0;
        end else if (byte_valid) begin
            csum_q <= csum_q ^ s_data;
        end
    end
`endif

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q != StDone);
    assign done       = (state_q == StDone);
    assign error      = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by the driver, popped by a monitor.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'd0;
    logic              s_ready;
    logic              reload = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0]  csum_m;
    logic [41:0] exp_q[$];

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h expected none",
                         imem_addr, imem_wdata);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e[41:32]));
                chk("write_data", imem_wdata, e[31:0]);
            end
        end
    end

    // Offer one byte after 'gaps' idle cycles; it transfers at the following rising edge.
    task automatic send_byte(input logic [7:0] b, input int unsigned gaps);
        for (int i = 0; i < int'(gaps); i++) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        chk("s_ready_while_loading", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk);
    endtask

    task automatic send_hdr(input logic [15:0] n, input int unsigned gaps);
        csum_m = 8'd0;
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [9:0] addr, input bit rnd);
        exp_q.push_back({addr, w});
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            csum_m = csum_m ^ b;
            send_byte(b, rnd ? $urandom_range(0, 3) : 0);
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // After the last data byte: final write visible, then hold released one cycle later.
    task automatic finish_ok(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_m, 0);
        idle_in();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
`else
        idle_in();
        chk({tag, "_last_we"}, 32'(imem_we), 32'd1);
        chk({tag, "_last_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_last_ready"}, 32'(s_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_we_off"}, 32'(imem_we), 32'd0);
`endif
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_reset_outputs("rst");

        // Two-word image: 02 00 | 13 05 A0 00 | 6F 00 00 00
        send_hdr(16'd2, 0);
        send_word(32'h00A0_0513, 10'd0, 1'b0);
        send_word(32'h0000_006F, 10'd1, 1'b0);
        finish_ok("load2");

        // Same image with random idle gaps between bytes
        do_reset();
        send_hdr(16'd2, 2);
        send_word(32'h00A0_0513, 10'd0, 1'b1);
        send_word(32'h0000_006F, 10'd1, 1'b1);
        finish_ok("gaps");

        // Zero count goes straight to done, no writes
        do_reset();
        send_hdr(16'd0, 0);
        idle_in();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_hold", 32'(cpu_hold), 32'd0);
        chk("zero_ready", 32'(s_ready), 32'd0);

        // Oversize count 01 04 = 1025 words
        do_reset();
        send_hdr(16'h0401, 0);
        idle_in();
        chk("over_error", 32'(error), 32'd1);
        chk("over_hold", 32'(cpu_hold), 32'd1);
        chk("over_ready", 32'(s_ready), 32'd0);
        chk("over_done", 32'(done), 32'd0);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("err_reload_error", 32'(error), 32'd0);
        chk("err_reload_ready", 32'(s_ready), 32'd1);

        // Reset after 6 bytes: word 0 already written, second word abandoned
        do_reset();
        send_hdr(16'd2, 0);
        send_word(32'h00A0_0513, 10'd0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk_reset_outputs("midrst");
        send_hdr(16'd2, 0);
        send_word(32'h00A0_0513, 10'd0, 1'b0);
        send_word(32'h0000_006F, 10'd1, 1'b0);
        finish_ok("after_rst");

        // Reload from done; second image overwrites addr 0
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_hold", 32'(cpu_hold), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_ready", 32'(s_ready), 32'd1);
        send_hdr(16'd1, 0);
        send_word(32'h0010_0093, 10'd0, 1'b0);
        finish_ok("reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: last write still happens, hold stays asserted
        do_reset();
        send_hdr(16'd2, 0);
        send_word(32'h00A0_0513, 10'd0, 1'b0);
        send_word(32'h0000_006F, 10'd1, 1'b0);
        send_byte(csum_m ^ 8'h01, 0);
        idle_in();
        chk("csum_bad_error", 32'(error), 32'd1);
        chk("csum_bad_hold", 32'(cpu_hold), 32'd1);
        chk("csum_bad_drained", exp_q.size(), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
